// File: rtl/asrv32_uart_tx_pkg.sv
// asrv32_uart_tx_pkg: register word offsets, STATUS bit indices and shifter FSM states
// shared by the UART transmitter and anything that decodes its register window.
package asrv32_uart_tx_pkg;
    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_BAUDDIV = 2'd2;
    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;
endpackage

// File: rtl/asrv32_uart_tx_if.sv
// asrv32_uart_tx_if: data-bus slave port of the UART (core store/load side).
interface asrv32_uart_tx_if;
    logic [31:0] i_data_addr;
    logic [31:0] i_data_in;
    logic [3:0]  i_wr_mask;
    logic        i_wr_en;
    logic        i_rd_en;
    logic [31:0] o_data_out;
    logic        o_ack;
    modport master (output i_data_addr, i_data_in, i_wr_mask, i_wr_en, i_rd_en,
                    input o_data_out, o_ack);
    modport slave (input i_data_addr, i_data_in, i_wr_mask, i_wr_en, i_rd_en,
                   output o_data_out, o_ack);
endinterface

// File: rtl/asrv32_sync_fifo.sv
// asrv32_sync_fifo: single-clock FIFO; pushes when full and pops when empty are ignored.
module asrv32_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = DEPTH[AW:0];
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0] count_q;
    logic push_ok, pop_ok;
    assign full_o  = count_q == FULL;
    assign empty_o = count_q == '0;
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    always_ff @(posedge clk)
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + AW'(push_ok);
            rd_ptr_q <= rd_ptr_q + AW'(pop_ok);
            count_q  <= count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end
endmodule

// File: rtl/asrv32_uart_tx.sv
// asrv32_uart_tx: memory-mapped UART transmitter (TXDATA/STATUS/BAUDDIV), LSB-first 8N1,
// or 8E1 when ASRV32_UART_PARITY_EN is defined.
module asrv32_uart_tx #(
    parameter logic [31:0] BASE_ADDR     = 32'h8000_0000,
    parameter int          FIFO_DEPTH    = 8,
    parameter logic [15:0] BAUDDIV_RESET = 16'd434
) (
    input  logic                 clk,
    input  logic                 rst,
    asrv32_uart_tx_if.slave      bus,
    output logic                 o_tx,
    output logic                 o_irq
);
    import asrv32_uart_tx_pkg::*;
`ifdef ASRV32_UART_PARITY_EN
    localparam state_e AFTER_DATA = S_PARITY;
`else
    localparam state_e AFTER_DATA = S_STOP;
`endif
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    state_e state_q, state_d;
    logic [15:0] baud_q, baud_d, cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] byte_q, byte_d, head;
    logic ovf_q, ovf_d, ack_q, irq_q;
    logic [31:0] rdata_q, rdata;
    logic [CW-1:0] count;
    logic in_win, wr, rd, push, pop, full, empty, busy, bit_end, unused_ok;
    logic [1:0] off;
    assign in_win    = bus.i_data_addr[31:4] == BASE_ADDR[31:4];
    assign off       = bus.i_data_addr[3:2];
    assign wr        = bus.i_wr_en & in_win;
    assign rd        = bus.i_rd_en & in_win;
    assign push      = wr && off == REG_TXDATA && bus.i_wr_mask[0];
    assign busy      = state_q != S_IDLE;
    assign bit_end   = cnt_q == '0;
    assign unused_ok = ^{bus.i_data_addr[1:0], bus.i_data_in[31:16], bus.i_wr_mask[3:1]};
    asrv32_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .rst(rst), .push_i(push), .pop_i(pop), .data_i(bus.i_data_in[7:0]),
        .data_o(head), .full_o(full), .empty_o(empty), .count_o(count)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            baud_q  <= BAUDDIV_RESET;
            ovf_q   <= 1'b0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
            irq_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            baud_q  <= baud_d;
            ovf_q   <= ovf_d;
            ack_q   <= wr | rd;
            rdata_q <= rd ? rdata : '0;
            irq_q   <= count == '0 && !busy;
        end
    end
    // Bit counter reloads at every boundary from the baud value in force then,
    // so a mid-frame BAUDDIV write only affects the following bits.
    always_comb begin
        pop    = !empty && (state_q == S_IDLE || (state_q == S_STOP && bit_end));
        cnt_d  = (busy && !bit_end) ? cnt_q - 16'd1 : baud_q - 16'd1;
        byte_d = pop ? head : byte_q;
        bit_d  = (state_q == S_DATA && bit_end) ? bit_q + 3'd1 : bit_q;
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = pop ? S_START : S_IDLE;
            S_START:  state_d = bit_end ? S_DATA : S_START;
            S_DATA:   state_d = (bit_end && bit_q == 3'd7) ? AFTER_DATA : S_DATA;
            S_PARITY: state_d = bit_end ? S_STOP : S_PARITY;
            S_STOP:   state_d = bit_end ? (pop ? S_START : S_IDLE) : S_STOP;
            default:  state_d = S_IDLE;
        endcase
    end
    always_comb begin
        o_tx = state_q == S_START ? 1'b0 :
               state_q == S_DATA  ? byte_q[bit_q] :
               state_q == S_PARITY ? ^byte_q : 1'b1;
    end
    always_comb begin
        rdata = '0;
        if (off == REG_STATUS) begin
            rdata[ST_FULL]  = full;
            rdata[ST_EMPTY] = empty;
            rdata[ST_BUSY]  = busy;
            rdata[ST_OVF]   = ovf_q;
        end
        if (off == REG_BAUDDIV) rdata[15:0] = baud_q;
        baud_d = (wr && off == REG_BAUDDIV) ?
                 (bus.i_data_in[15:0] == '0 ? 16'd1 : bus.i_data_in[15:0]) : baud_q;
        ovf_d  = (push && full) || (ovf_q && !(wr && off == REG_STATUS && bus.i_data_in[ST_OVF]));
    end
    assign bus.o_ack      = ack_q;
    assign bus.o_data_out = rdata_q;
    assign o_irq          = irq_q;
endmodule
